// File: rtl/mlcd_bus_reader.sv
// 8080-style LCD bus read engine with an Avalon-MM register front end.
// Optional interrupt support is enabled by defining MLCD_RD_IRQ_EN.
module mlcd_bus_reader #(
    parameter int DATA_W  = 16,
    parameter int RDL_RST = 8,
    parameter int RDH_RST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] lcd_data_in,
    output logic              lcd_cs_n,
    output logic              lcd_rs,
    output logic              lcd_rd_n,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic              w_capture;

    logic              r_pend;
    logic              r_rs;
    logic              r_rs_q;
    logic [7:0]        r_rdl;
    logic [7:0]        r_rdh;
    logic [7:0]        r_rdl_q;
    logic [7:0]        r_rdh_q;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ovr;
    logic              r_lcd_cs_n;
    logic              r_lcd_rd_n;
    logic              r_lcd_rs;

    logic              w_wr;
    logic              w_wr_ctrl;
    logic              w_rd_data;
    logic              w_busy;
    logic              w_start;
    logic              w_ie;
    logic              w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_ctrl = w_wr & (address == 2'd1);
    assign w_rd_data = chipselect & ~read_n & (address == 2'd0);
    assign w_busy    = (r_state != S_IDLE);
    // A START is taken only when nothing is running or already queued for SETUP.
    assign w_start   = w_wr_ctrl & writedata[0] & ~w_busy & ~r_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_state_nxt = S_STROBE;
                w_cnt_nxt   = (r_rdl_q == 8'd0) ? 8'd0 : r_rdl_q - 8'd1;
            end
            S_STROBE: begin
                if (r_cnt == 8'd0) begin
                    w_capture = 1'b1;
                    if (r_rdh_q == 8'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = r_rdh_q - 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 8'd0) w_state_nxt = S_IDLE;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pins are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lcd_cs_n <= 1'b1;
            r_lcd_rd_n <= 1'b1;
            r_lcd_rs   <= 1'b0;
        end else begin
            r_lcd_cs_n <= (w_state_nxt == S_IDLE);
            r_lcd_rd_n <= (w_state_nxt != S_STROBE);
            if ((r_state == S_IDLE) && (w_state_nxt == S_SETUP)) r_lcd_rs <= r_rs_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend  <= 1'b0;
            r_rs    <= 1'b0;
            r_rs_q  <= 1'b0;
            r_rdl   <= 8'(RDL_RST);
            r_rdh   <= 8'(RDH_RST);
            r_rdl_q <= 8'(RDL_RST);
            r_rdh_q <= 8'(RDH_RST);
        end else begin
            if (w_start)     r_pend <= 1'b1;
            else if (r_pend) r_pend <= 1'b0;
            if (w_wr_ctrl) r_rs <= writedata[1];
            if (w_start) begin
                r_rs_q  <= writedata[1];
                r_rdl_q <= r_rdl;
                r_rdh_q <= r_rdh;
            end
            if (w_wr && (address == 2'd3)) begin
                r_rdl <= writedata[7:0];
                r_rdh <= writedata[15:8];
            end
        end
    end

    // A capture on the same edge as a DATA read keeps valid set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_capture) r_data <= lcd_data_in;
            if (w_capture)      r_valid <= 1'b1;
            else if (w_rd_data) r_valid <= 1'b0;
            if (w_capture && r_valid)          r_ovr <= 1'b1;
            else if (w_wr && (address == 2'd2)) r_ovr <= 1'b0;
        end
    end

`ifdef MLCD_RD_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ie <= writedata[2];
            r_irq <= r_valid & r_ie;
        end
    end

    assign w_ie     = r_ie;
    assign irq      = r_irq;
    assign w_unused = ^writedata[31:16];
`else
    assign w_ie     = 1'b0;
    assign irq      = 1'b0;
    assign w_unused = ^{writedata[31:16], writedata[2]};
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[DATA_W-1:0] = r_data;
            2'd1:    readdata[2:1]        = {w_ie, r_rs};
            2'd2:    readdata[2:0]        = {r_ovr, r_valid, w_busy};
            default: readdata[15:0]       = {r_rdh, r_rdl};
        endcase
    end

    assign lcd_cs_n = r_lcd_cs_n;
    assign lcd_rd_n = r_lcd_rd_n;
    assign lcd_rs   = r_lcd_rs;

endmodule

// File: doc/mlcd_bus_reader.md
# mlcd_bus_reader

Avalon-MM slave that performs 8080-style read cycles on the MCU LCD parallel bus, the read-side counterpart of the 16-bit LCD data output PIO. On a CPU start command it drives the LCD chip-select, register-select and read strobe with programmable timing. It captures the 16-bit bus value and presents it to the Nios II through a data/status register pair. It sits in the Qsys system next to the LCD output PIOs. The LCD bus turnaround (tristate) is handled outside this block.

## Interface
- `DATA_W`, 16: LCD data bus width, from 1 to 16.
- `RDL_RST`, 8: reset value of the read-strobe low time, in clocks.
- `RDH_RST`, 4: reset value of the post-strobe hold time, in clocks.

Ports:
- `clk` in 1: system clock. The block uses a single clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `read_n` in 1: active-low read, zero wait states.
- `write_n` in 1: active-low write.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read mux, zero-extended.
- `lcd_data_in` in DATA_W: LCD bus input.
- `lcd_cs_n` out 1: LCD chip select, registered.
- `lcd_rs` out 1: LCD register select, registered.
- `lcd_rd_n` out 1: LCD read strobe, registered.
- `irq` out 1: interrupt, level, active-high.

## Operation
Register map:
- Address 0, DATA (R): last captured word. A read with `chipselect & ~read_n` clears `valid`. Writes are ignored.
- Address 1, CTRL (W/R):
  - bit0 START: writing 1 starts a transaction; this bit reads back as 0.
  - bit1 RS value for the transaction.
  - bit2 IE (interrupt enable, see Configuration).
- Address 2, STATUS (R): bit0 `busy`, bit1 `valid`, bit2 `overrun`. Any write clears `overrun`.
- Address 3, TIMING (R/W): [7:0] RDL, [15:8] RDH.

FSM: IDLE → SETUP → STROBE → HOLD → IDLE.
- IDLE: `lcd_cs_n`=1, `lcd_rd_n`=1, `busy`=0. START latches RS, RDL and RDH, then goes to SETUP.
- SETUP, 1 clock: `lcd_cs_n`=0, `lcd_rs`=RS, `busy`=1.
- STROBE, max(RDL,1) clocks: `lcd_rd_n`=0. A counter is loaded on entry.
  - On the last STROBE clock edge: DATA ← `lcd_data_in`, `valid` ← 1, `lcd_rd_n` ← 1.
  - If `valid` was already 1 at that edge, `overrun` ← 1.
- HOLD, RDH clocks: `lcd_cs_n`=0, `lcd_rd_n`=1. RDH=0 skips HOLD and goes to IDLE.

Rules:
- START while `busy` is ignored and has no side effects.
- TIMING or RS writes while `busy` apply only to the next transaction.
- A DATA read on the same edge as a capture: the capture wins and `valid` stays 1.
- Reset values: `lcd_cs_n`=1, `lcd_rd_n`=1, `lcd_rs`=0, DATA=0, `valid`=0, `overrun`=0, `busy`=0, IE=0, TIMING={RDH_RST,RDL_RST}, `irq`=0.
- Reset mid-transaction returns every output to its reset value immediately (asynchronously) and abandons the capture.

## Timing
- START is written at edge T.
  - T+1: `lcd_cs_n`=0, `lcd_rs` valid.
  - T+2: `lcd_rd_n`=0, held for L = max(RDL,1) clocks.
  - T+2+L: data captured, `lcd_rd_n`=1, `valid`=1.
  - T+2+L+RDH: `lcd_cs_n`=1, `busy`=0.
- The earliest next START is accepted at the edge where `busy` reads 0.
- `lcd_data_in` must be stable for setup/hold around the capture edge. The block has no synchronizer; the LCD interface is synchronous to the bus timing it drives.

## Configuration
- `MLCD_RD_IRQ_EN` defined:
  - CTRL bit2 IE is implemented.
  - `irq` = `valid & IE`, registered; it deasserts one clock after DATA is read.
- `MLCD_RD_IRQ_EN` undefined:
  - IE is not implemented and reads 0.
  - `irq` is tied to 0.

## Test plan
- Reset then read TIMING → 0x0000_0408. STATUS → 0. `lcd_cs_n`=`lcd_rd_n`=1.
- RDL=3, RDH=2, `lcd_data_in`=0xA5C3, write CTRL=0x3 → `lcd_rs`=1. `lcd_rd_n` low exactly 3 clocks. `lcd_cs_n` low 1+3+2=6 clocks. DATA=0x0000_A5C3. STATUS=0x2. Read DATA again → STATUS=0x0.
- RDL=0, RDH=0 → strobe 1 clock. `busy` high 2 clocks total. Capture is correct.
- Two transactions without reading DATA (0x1111, then 0x2222) → DATA=0x2222, STATUS=0x6. Write STATUS → STATUS=0x2.
- START written while `busy` (RDL=10) → only one strobe pulse. Deassert `reset_n` during STROBE → `lcd_rd_n`/`lcd_cs_n` high immediately, STATUS=0, DATA=0.
- With `MLCD_RD_IRQ_EN`, CTRL=0x5, complete a read → `irq`=1 until the DATA read, then 0 on the next clock. Without the macro → `irq` stays 0 and CTRL bit2 reads 0.
